popcount_accumulator: RTL and testbench
=======================================

Name: popcount_accumulator

Overview:
Downstream consumer of the combinational bit-counter stage. Accepts one popcount value per handshake, accumulates a frame of counts into a saturating sum, then presents the frame total, slice count and threshold flag on a valid/ready output. Intended for multi-word Hamming-weight and majority checks in generated circuits.

Parameters:
BITSIZE, 10, width of the upstream bitslice; maximum legal in_count value
COUNTERSIZE, 4, width of in_count (matches the upstream count width)
FRAMELEN, 8, maximum number of counts per frame
ACCSIZE, 8, width of out_sum
THRESHOLD, 16, compare value for out_over
NW, $clog2(FRAMELEN+1), derived (localparam); width of out_nslices

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  in_count valid
in_ready  out  1  block can accept in_count
in_count  in  COUNTERSIZE  popcount from the upstream bit counter
in_last  in  1  closes the frame early with this beat
out_valid  out  1  frame result valid
out_ready  in  1  consumer accepts the result
out_sum  out  ACCSIZE  saturating sum of the frame's counts
out_nslices  out  NW  number of counts accepted in the frame
out_over  out  1  out_sum >= THRESHOLD
out_sat  out  1  sum saturated during the frame
err_range  out  1  sticky range error (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clk edge): state=ACCUM, sum=0, slice counter=0, out_valid=0, out_sum=0, out_nslices=0, out_over=0, out_sat=0, err_range=0. Reset takes priority over all other events, including mid-frame and during HOLD; any partial frame is discarded.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept condition: in_valid && in_ready.
  - On accept: sum <= min(sum + in_count, 2^ACCSIZE-1); counter increments.
  - The sat flag is set if the true sum exceeds 2^ACCSIZE-1. It stays set until the frame is emitted.
- Frame close: an accept with in_last=1, or an accept that brings the counter to FRAMELEN.
  - On close, the next cycle is HOLD with the outputs registered from the final sum: out_sum, out_nslices, out_over, out_sat.
  - Latency from the closing accept to out_valid=1 is 1 cycle.
- HOLD:
  - Outputs stay stable while out_ready=0.
  - On out_ready=1, the next state is ACCUM, with sum, counter and sat cleared and out_valid=0.
  - There is no same-cycle bypass: at least 1 idle cycle between frames on the input side.
- Dead cycles: in_valid=0 in ACCUM leaves all state unchanged, with no timeout.
- in_last while counter=0: the frame closes with nslices=1.
- in_count is sampled only on accept; values while in_ready=0 are ignored.
- out_over compare: unsigned, against the saturated sum.
- in_count is zero-extended to ACCSIZE+1 bits before the add; the saturation check uses the carry.

Optional Feature:
Macro: POPACC_RANGECHK_EN
- Defined: an accepted in_count > BITSIZE is clamped to BITSIZE before accumulation. err_range is set and stays set (sticky) until rst.
- Undefined: in_count is accumulated raw, and err_range is tied to 0.

Test Plan:
- FRAMELEN=8 with 8 accepts of in_count=5 and in_last=0 -> one cycle after the 8th accept: out_valid=1, out_sum=40, out_nslices=8, out_over=1, out_sat=0.
- Accepts 3 then 4, the second with in_last=1 -> out_sum=7, out_nslices=2, out_over=0; in_ready=0 while out_valid=1.
- Hold out_ready=0 for 3 cycles in HOLD while driving in_valid=1 -> outputs unchanged and no input accepted. Raise out_ready -> the next cycle is ACCUM with in_ready=1, and the following frame sum starts from 0.
- ACCSIZE=6 with 8 accepts of in_count=10 -> out_sum=63, out_sat=1, out_over=1. The next frame, with 1 accept of 2 plus in_last -> out_sum=2, out_sat=0.
- Assert rst after 3 accepts of 9 -> all outputs 0 the next cycle. A subsequent frame of 1 accept of 1 plus in_last -> out_sum=1, out_nslices=1.
- With POPACC_RANGECHK_EN defined: accept in_count=12 plus in_last -> out_sum=10 and err_range=1, with err_range remaining 1 after the next frame. With the macro undefined: out_sum=12 and err_range=0.

Source files
------------

// File: rtl/popcount_accumulator.sv
// Accumulates per-slice popcounts into a saturating frame sum and emits the frame total on a valid/ready port.
// Optional: define POPACC_RANGECHK_EN to clamp counts above BITSIZE and raise a sticky err_range flag.
module popcount_accumulator #(
  parameter int BITSIZE     = 10,
  parameter int COUNTERSIZE = 4,
  parameter int FRAMELEN    = 8,
  parameter int ACCSIZE     = 8,
  parameter int THRESHOLD   = 16,
  localparam int NW         = $clog2(FRAMELEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COUNTERSIZE-1:0] in_count,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACCSIZE-1:0]     out_sum,
  output logic [NW-1:0]          out_nslices,
  output logic                   out_over,
  output logic                   out_sat,
  output logic                   err_range
);

  // Handshake: a beat transfers on a rising clk edge where valid && ready;
  // ready never depends on valid, and a presented result holds until taken.
  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                 state;
  logic [ACCSIZE-1:0]     sum;
  logic [NW-1:0]          cnt;
  logic                   sat;

  logic [COUNTERSIZE-1:0] count_eff;
  logic                   range_bad;
  logic [ACCSIZE:0]       add_full;
  logic                   carry;
  logic [ACCSIZE-1:0]     sum_next;
  logic [NW-1:0]          cnt_next;
  logic                   accept;
  logic                   close;
  logic                   over_next;

`ifdef POPACC_RANGECHK_EN
  always_comb begin
    range_bad = 32'(in_count) > 32'(BITSIZE);
    count_eff = range_bad ? COUNTERSIZE'(BITSIZE) : in_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_range <= 1'b0;
    end else if (accept && range_bad) begin
      err_range <= 1'b1;
    end
  end
`else
  always_comb begin
    range_bad = 1'b0;
    count_eff = in_count;
  end

  assign err_range = range_bad;
`endif

  // The extra top bit of the adder is the overflow carry that drives saturation.
  always_comb begin
    add_full  = {1'b0, sum} + (ACCSIZE + 1)'(count_eff);
    carry     = add_full[ACCSIZE];
    sum_next  = carry ? {ACCSIZE{1'b1}} : add_full[ACCSIZE-1:0];
    cnt_next  = cnt + NW'(1);
    accept    = in_valid && in_ready;
    close     = accept && (in_last || (cnt_next == NW'(FRAMELEN)));
    over_next = 32'(sum_next) >= 32'(THRESHOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACCUM;
      sum         <= '0;
      cnt         <= '0;
      sat         <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_sum     <= '0;
      out_nslices <= '0;
      out_over    <= 1'b0;
      out_sat     <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            sum <= sum_next;
            cnt <= cnt_next;
            sat <= sat | carry;
          end
          if (close) begin
            state       <= HOLD;
            in_ready    <= 1'b0;
            out_valid   <= 1'b1;
            out_sum     <= sum_next;
            out_nslices <= cnt_next;
            out_over    <= over_next;
            out_sat     <= sat | carry;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            sum       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_accumulator.sv
// Directed bench for popcount_accumulator: an 8-bit accumulator and a 6-bit one share one input stream.
module tb_popcount_accumulator;

  localparam int NW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_count;
  logic       in_last;
  logic       out_ready;

  logic       in_ready, out_valid, out_over, out_sat, err_range;
  logic [7:0] out_sum;
  logic [NW-1:0] out_nslices;

  logic       in_ready6, out_valid6, out_over6, out_sat6, err_range6;
  logic [5:0] out_sum6;
  logic [NW-1:0] out_nslices6;

  int vectors = 0;
  int miscompares = 0;

  popcount_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_count(in_count), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_nslices(out_nslices),
    .out_over(out_over), .out_sat(out_sat), .err_range(err_range)
  );

  popcount_accumulator #(.ACCSIZE(6)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6),
    .in_count(in_count), .in_last(in_last), .out_valid(out_valid6),
    .out_ready(out_ready), .out_sum(out_sum6), .out_nslices(out_nslices6),
    .out_over(out_over6), .out_sat(out_sat6), .err_range(err_range6)
  );

  always #5 clk = ~clk;

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] c, input logic last);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_count = c;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_count = 4'd0;
  endtask

  task automatic release_frame();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] s, input logic [NW-1:0] n,
                             input logic ov, input logic st);
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== s ||
        out_nslices !== n || out_over !== ov || out_sat !== st) begin
      miscompares++;
      $display("FAIL %s: valid=%b ready=%b sum=%0d n=%0d over=%b sat=%b required 1/0 sum=%0d n=%0d over=%b sat=%b",
               name, out_valid, in_ready, out_sum, out_nslices, out_over, out_sat, s, n, ov, st);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 8'd0 || out_nslices !== 4'd0 ||
        out_over !== 1'b0 || out_sat !== 1'b0 || err_range !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: valid=%b ready=%b sum=%0d n=%0d over=%b sat=%b err=%b required 0 1 0 0 0 0 0",
               out_valid, in_ready, out_sum, out_nslices, out_over, out_sat, err_range);
    end
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < 8; i++) send(4'd5, 1'b0);
    check_frame("full_frame", 8'd40, 4'd8, 1'b1, 1'b0);
    release_frame();
  endtask

  task automatic test_early_last();
    send(4'd3, 1'b0);
    send(4'd4, 1'b1);
    check_frame("early_last", 8'd7, 4'd2, 1'b0, 1'b0);
  endtask

  // Continues from the HOLD left by test_early_last.
  task automatic test_hold_stall();
    in_valid = 1'b1;
    in_count = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_frame("hold_stall", 8'd7, 4'd2, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    release_frame();
    send(4'd1, 1'b1);
    check_frame("after_stall", 8'd1, 4'd1, 1'b0, 1'b0);
    release_frame();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 8; i++) send(4'd10, 1'b0);
    check_frame("sat_acc8", 8'd80, 4'd8, 1'b1, 1'b0);
    vectors++;
    if (out_valid6 !== 1'b1 || out_sum6 !== 6'd63 || out_sat6 !== 1'b1 || out_over6 !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_acc6: valid=%b sum=%0d sat=%b over=%b required 1 63 1 1",
               out_valid6, out_sum6, out_sat6, out_over6);
    end
    release_frame();
    send(4'd2, 1'b1);
    vectors++;
    if (out_valid6 !== 1'b1 || out_sum6 !== 6'd2 || out_sat6 !== 1'b0 || out_nslices6 !== 4'd1) begin
      miscompares++;
      $display("FAIL sat_clear: valid=%b sum=%0d sat=%b n=%0d required 1 2 0 1",
               out_valid6, out_sum6, out_sat6, out_nslices6);
    end
    release_frame();
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 3; i++) send(4'd9, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 8'd0 || out_nslices !== 4'd0 ||
        out_over !== 1'b0 || out_sat !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: valid=%b ready=%b sum=%0d n=%0d over=%b sat=%b required 0 1 0 0 0 0",
               out_valid, in_ready, out_sum, out_nslices, out_over, out_sat);
    end
    send(4'd1, 1'b1);
    check_frame("post_reset", 8'd1, 4'd1, 1'b0, 1'b0);
    // Reset while a result is being held drops it.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_hold: valid=%b ready=%b sum=%0d required 0 1 0", out_valid, in_ready, out_sum);
    end
  endtask

  task automatic test_dead_cycles();
    send(4'd2, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL dead_idle: valid=%b ready=%b required 0 1", out_valid, in_ready);
    end
    send(4'd3, 1'b1);
    check_frame("dead_cycles", 8'd5, 4'd2, 1'b0, 1'b0);
    release_frame();
  endtask

  task automatic test_range();
    logic [7:0] exp_sum;
    logic       exp_err;
`ifdef POPACC_RANGECHK_EN
    exp_sum = 8'd10;
    exp_err = 1'b1;
`else
    exp_sum = 8'd12;
    exp_err = 1'b0;
`endif
    send(4'd12, 1'b1);
    check_frame("range_sum", exp_sum, 4'd1, 1'b0, 1'b0);
    vectors++;
    if (err_range !== exp_err) begin
      miscompares++;
      $display("FAIL range_err: err_range=%b required %b", err_range, exp_err);
    end
    release_frame();
    send(4'd1, 1'b1);
    check_frame("range_next", 8'd1, 4'd1, 1'b0, 1'b0);
    vectors++;
    if (err_range !== exp_err) begin
      miscompares++;
      $display("FAIL range_sticky: err_range=%b required %b", err_range, exp_err);
    end
    release_frame();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_count  = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_early_last();
    test_hold_stall();
    test_saturation();
    test_reset_midframe();
    test_dead_cycles();
    test_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
